// File: rtl/mac_pkg.sv
// Shared types and saturation limits for the mac_seq multiply-accumulate stage.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mac_state_t;

    function automatic longint sat_max(input int w);
        return (longint'(1) << (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/mult.sv
// Pipelined multiplier primitive: low n bits of A*B, delayed by p register stages.
module mult #(
    parameter int n = 16,
    parameter int p = 1
) (
    input  logic         Clock,
    input  logic         nReset,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    output logic [n-1:0] P
);

    logic [n-1:0] w_prod;
    logic [n-1:0] r_pipe [p];

    // Low n bits are identical for signed and unsigned operands of width n.
    assign w_prod = A * B;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < p; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_prod;
            for (int i = 1; i < p; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign P = r_pipe[p-1];

endmodule

// File: rtl/mac_seq.sv
// Sequential signed multiply-accumulate: takes Len operand pairs over valid/ready,
// sums their products into a saturating accumulator and pulses Done at the end.
//
// state | meaning
// IDLE  | waiting for Start, Acc holds last result
// RUN   | accepting pairs while Rem != 0
// DRAIN | last product in flight to the accumulator
// DONE  | one-cycle Done pulse, final Acc valid
module mac_seq
    import mac_pkg::*;
#(
    parameter int N     = 8,
    parameter int ACC_W = 16,
    parameter int LEN_W = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic [LEN_W-1:0]        Len,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic [N-1:0]            A,
    input  logic [N-1:0]            B,
    output logic signed [ACC_W-1:0] Acc,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Ovf
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

    mac_state_t r_state;
    mac_state_t w_state_nxt;

    logic [LEN_W-1:0]        r_rem;
    logic                    r_pvld;
    logic                    r_ovf;
    logic signed [ACC_W-1:0] r_acc;

    logic                    w_start_ok;
    logic                    w_accept;
    logic [2*N-1:0]          w_a_ext;
    logic [2*N-1:0]          w_b_ext;
    logic [2*N-1:0]          w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W:0]   w_sum;
    logic                    w_pos_ovf;
    logic                    w_neg_ovf;
    logic signed [ACC_W-1:0] w_acc_sat;

    assign w_start_ok = Start && ((r_state == IDLE) || (r_state == DONE));
    assign InReady    = (r_state == RUN) && (r_rem != '0);
    assign w_accept   = InValid && InReady;
    assign Busy       = (r_state == RUN) || (r_state == DRAIN);
    assign Done       = (r_state == DONE);
    assign Acc        = r_acc;
    assign Ovf        = r_ovf;

    // The multiplier registers every cycle; PVld marks which of its outputs belong to the run.
    assign w_a_ext = (2*N)'($signed(A));
    assign w_b_ext = (2*N)'($signed(B));

    mult #(
        .n (2*N),
        .p (1)
    ) mul0 (
        .Clock  (Clock),
        .nReset (~Reset),
        .A      (w_a_ext),
        .B      (w_b_ext),
        .P      (w_prod)
    );

    assign w_prod_ext = ACC_W'($signed(w_prod));
    assign w_sum      = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_prod_ext);
    assign w_pos_ovf  = ~w_sum[ACC_W] &  w_sum[ACC_W-1];
    assign w_neg_ovf  =  w_sum[ACC_W] & ~w_sum[ACC_W-1];
    assign w_acc_sat  = w_pos_ovf ? ACC_MAX :
                        w_neg_ovf ? ACC_MIN : w_sum[ACC_W-1:0];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_start_ok)            w_state_nxt = (Len == '0) ? DONE : RUN;
                else if (r_state == DONE)  w_state_nxt = IDLE;
            end
            RUN: begin
                if (w_accept && (r_rem == LEN_W'(1))) w_state_nxt = DRAIN;
            end
            DRAIN:   w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_rem  <= '0;
            r_pvld <= 1'b0;
            r_ovf  <= 1'b0;
            r_acc  <= '0;
        end else if (w_start_ok) begin
            r_rem  <= Len;
            r_pvld <= 1'b0;
            r_ovf  <= 1'b0;
            r_acc  <= '0;
        end else begin
            r_pvld <= w_accept;
            if (w_accept) r_rem <= r_rem - LEN_W'(1);
            if (r_pvld) begin
                r_acc <= w_acc_sat;
                if (w_pos_ovf || w_neg_ovf) r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mac_seq.md
# mac_seq

Sequential signed multiply-accumulate stage. It accepts a programmed number of 8-bit operand pairs over a valid/ready handshake and multiplies each pair through the pipelined `mult` primitive. Each product is added into a saturating accumulator, and `Done` pulses when the last product has been summed. The block sits downstream of the multiplier primitives and upstream of the register-file write-back, which samples `Acc` on `Done`.

## Interface
- `N`, 8, operand width (signed)
- `ACC_W`, 16, accumulator width (signed); requires `ACC_W >= 2*N`
- `LEN_W`, 4, width of the term count
- `Clock`  in  1  single clock; all state changes on the rising edge
- `Reset`  in  1  reset, asynchronous, active-high
- `Start`  in  1  begins a run; honoured only in IDLE or DONE
- `Len`  in  LEN_W  number of pairs in the run; sampled on the accepted `Start`
- `InValid`  in  1  `A`/`B` hold a pair
- `InReady`  out  1  block will accept a pair this cycle
- `A`, `B`  in  N  signed operands
- `Acc`  out  ACC_W  signed accumulated sum; holds its value after the run
- `Busy`  out  1  state is RUN or DRAIN
- `Done`  out  1  one-cycle pulse, final `Acc` valid
- `Ovf`  out  1  sticky saturation flag; cleared on the accepted `Start`

## Operation
- **States:** IDLE, RUN, DRAIN, DONE. Encoding is 2 bits.
- **IDLE/DONE + `Start`:**
  - Clear `Acc` and `Ovf`.
  - Load remaining count `Rem` = `Len`.
  - If `Len` = 0, go to DONE. Otherwise go to RUN.
- **Busy + `Start`:** while `Busy` = 1, `Start` is ignored.
- **RUN:**
  - `InReady` = 1 while `Rem` ≠ 0.
  - A pair is accepted when `InValid` && `InReady`; accepting decrements `Rem`.
  - Accepting the last pair (`Rem` = 1) moves the state to DRAIN.
- **DRAIN:** `InReady` = 0. On the next edge the final product is added and the state moves to DONE.
- **DONE:**
  - `Done` = 1 for exactly one cycle on entry.
  - The state returns to IDLE on the following edge unless `Start` is present.
  - `Acc` holds its value in both DONE and IDLE.
- **Product:** `A` and `B` are sign-extended to 2N bits and applied to `mult` (n = 2N, p = 1). The result is an exact signed 2N-bit product, sign-extended to `ACC_W`.
- **Product valid:** `PVld` is a register set by an accepted pair. When `PVld` is set, `Acc` is updated on the next edge.
- **Accumulate rule:**
  - Signed add, saturating.
  - On positive overflow, `Acc` = 2^(ACC_W-1)-1 and `Ovf` is set.
  - On negative overflow, `Acc` = -2^(ACC_W-1) and `Ovf` is set.
  - Subsequent terms are added to the saturated value, so the sum can come back out of saturation.
- **Ignored inputs:** pairs presented outside RUN, or once `Rem` = 0, are ignored.

## Timing
- **Reset values:** every output and internal register clears asynchronously on `Reset` = 1.
  - `Acc` = 0, `Ovf` = 0, `Done` = 0, `Busy` = 0, `InReady` = 0.
  - State = IDLE, `PVld` = 0, `Rem` = 0.
  - The `mult` pipeline register is cleared through its `nReset` = ~`Reset`.
- **Reset mid-run:** the run is aborted and no `Done` is issued.
- **Start to first accept:** `Start` is sampled at edge E0. `InReady` = 1 during the cycle after E0. The first pair can therefore be accepted at edge E0+1.
- **Per-pair latency:** a pair accepted at edge E has its product registered at E. `Acc` includes that product after edge E+1.
- **Throughput:** one pair per cycle.
- **Run end:** the last pair is accepted at edge E.
  - State = DRAIN after E.
  - Final `Acc` and state = DONE after E+1, with `Done` = 1 during cycle E+1..E+2.
  - Minimum `Start`-to-`Done` time is `Len` + 2 cycles.
- **`Len` = 0:** `Done` = 1 in the cycle after the `Start` edge, with `Acc` = 0.
- **`Start` in DONE:** the new run starts and `Done` still lasts exactly one cycle.
- **Back-pressure:** `InValid` low in RUN stalls with no state change. No timeout.

## Structure
- Shared package `mac_pkg`:
  - state enum `mac_state_t` (IDLE, RUN, DRAIN, DONE)
  - the `ACC_W` saturation limits as functions of the parameter
- Single sub-module: existing `mult` instantiated as `mul0` (n = 2N, p = 1).
- Everything else (FSM, `Rem` counter, `PVld`, saturating adder) is inline in `mac_seq`.

## Test plan
- **Reset:** assert `Reset` mid-RUN after 2 of 4 pairs.
  - All outputs 0 and state IDLE immediately (asynchronous).
  - No `Done` pulse.
- **Basic run:** `Len` = 3, pairs (3,4), (-5,6), (7,-2), `InValid` constantly high.
  - `InReady` high for exactly 3 cycles.
  - `Acc` = 12, -18, -32 on consecutive edges.
  - `Done` one cycle at `Start` + 5, `Ovf` = 0.
- **Back-pressure:** `Len` = 2, `InValid` toggled 1,0,0,1 with pairs (2,2), (10,10).
  - `Acc` = 104.
  - `Done` 2 cycles after the second accept.
  - `Busy` high throughout.
- **Saturation:** `Len` = 4, all pairs (127,127) (product 16129).
  - `Acc` saturates to 32767 on the third term and stays there.
  - `Ovf` = 1, cleared by the next `Start`.
  - Negative counterpart (-128,127) gives -32768.
- **Edge cases:** `Len` = 0 gives `Done` the cycle after `Start`, with `Acc` = 0. Follow it with:
  - `Start` while `Busy` (ignored; `Acc` unaffected).
  - `Start` during DONE (new run begins, single-cycle `Done`).
- **Overrun:** `InValid` held high after `Rem` reaches 0.
  - `InReady` = 0.
  - Extra pairs do not change `Acc`.
